// File: rtl/path_pkg.sv
//------------------------------------------------------------------------------
// path_pkg
//   Shared definitions for the junction path word: turn-code values, hop field
//   width and the path composer state encoding (also used by junction-side
//   monitors, so the encoding must stay stable).
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package path_pkg;

  localparam int HOP_W = 2;

  localparam logic [HOP_W-1:0] DIR_END = 2'b00;  // junction disabled, lamps off
  localparam logic [HOP_W-1:0] DIR_T1  = 2'b01;
  localparam logic [HOP_W-1:0] DIR_T2  = 2'b10;
  localparam logic [HOP_W-1:0] DIR_T3  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no hops stored
    ST_COLLECT = 2'd1,  // 0 < hops stored < HOPS
    ST_SEND    = 2'd2   // complete path presented to the launcher
  } path_state_e;

endpackage

`default_nettype wire

// File: rtl/path_composer.sv
//------------------------------------------------------------------------------
// path_composer
//   Entry-gate route builder. Collects one turn code per hop handshake and
//   packs them MSB-first into a PATH_W-bit path word (hop 0 in the top field),
//   then offers the word to the route launcher over valid/ready.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     abort      in   synchronous flush to IDLE, highest priority
//     hop_valid  in   hop_code valid
//     hop_ready  out  composer accepts a hop this cycle
//     hop_code   in   turn code (00 = END)
//     hop_last   in   accepted hop closes the path
//     path_valid out  path_data holds a complete path
//     path_ready in   launcher takes path_data
//     path_data  out  packed path word
//     hop_count  out  hops stored in current path
//     err        out  one-cycle pulse: END received with no hops stored
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module path_composer
  import path_pkg::*;
#(
  parameter int HOPS   = 4,
  parameter int PATH_W = 2 * HOPS,
  parameter int CNT_W  = $clog2(HOPS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              hop_valid,
  output logic              hop_ready,
  input  logic [HOP_W-1:0]  hop_code,
  input  logic              hop_last,
  output logic              path_valid,
  input  logic              path_ready,
  output logic [PATH_W-1:0] path_data,
  output logic [CNT_W-1:0]  hop_count,
  output logic              err
);

  path_state_e       state_q;
  logic [PATH_W-1:0] path_data_q;
  logic [CNT_W-1:0]  hop_count_q;
  logic              err_q;

  // Handshake flags are pure state decodes; abort masks hop_ready so a
  // flushed cycle can never also accept a hop.
  assign hop_ready  = (state_q != ST_SEND) && !abort;
  assign path_valid = (state_q == ST_SEND);
  assign path_data  = path_data_q;
  assign hop_count  = hop_count_q;
  assign err        = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      path_data_q <= '0;
      hop_count_q <= '0;
      err_q       <= 1'b0;
    end else if (abort) begin
      state_q     <= ST_IDLE;
      path_data_q <= '0;
      hop_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_COLLECT: begin
          if (hop_valid) begin
            if (hop_code != DIR_END) begin
              // Field k = hop_count sits at [PATH_W-1-2k -: 2]; unrolled so
              // every part-select index is a constant.
              for (int i = 0; i < HOPS; i++) begin
                if (hop_count_q == CNT_W'(i)) begin
                  path_data_q[PATH_W-1-HOP_W*i -: HOP_W] <= hop_code;
                end
              end
              hop_count_q <= hop_count_q + CNT_W'(1);
              // Reaching HOPS closes the path regardless of hop_last.
              if (hop_last || (hop_count_q == CNT_W'(HOPS - 1))) begin
                state_q <= ST_SEND;
              end else begin
                state_q <= ST_COLLECT;
              end
            end else if (hop_count_q != '0) begin
              // END: trailing fields are already zero from the last clear.
              state_q <= ST_SEND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (path_ready) begin
            state_q     <= ST_IDLE;
            path_data_q <= '0;
            hop_count_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
